// File: rtl/epf_channel_multistate.sv
// N-state Markov burst-error channel for PAM-2^SYMBOL_W symbols, with a run-time loaded
// per-state probability table and built-in symbol/error/burst statistics counters.
module urng_64 #(
    parameter logic [63:0] SEED0 = 64'h1391A0B350391A0B,
    parameter logic [63:0] SEED1 = 64'h50391A0B0392A7D3,
    parameter logic [63:0] SEED2 = 64'h0392A7D350391A0B
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic [63:0] r
);
    // Three-component combined 64-bit Tausworthe generator.
    logic [63:0] z1, z2, z3;
    logic [63:0] z1_next, z2_next, z3_next;

    always_comb begin
        z1_next = ((z1 & 64'hFFFF_FFFF_FFFF_FFFE) << 10) ^ (((z1 << 1) ^ z1) >> 53);
        z2_next = ((z2 & 64'hFFFF_FFFF_FFFF_FE00) << 5) ^ (((z2 << 24) ^ z2) >> 50);
        z3_next = ((z3 & 64'hFFFF_FFFF_FFFF_F000) << 29) ^ (((z3 << 3) ^ z3) >> 23);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            z1 <= SEED0;
            z2 <= SEED1;
            z3 <= SEED2;
        end else if (en) begin
            z1 <= z1_next;
            z2 <= z2_next;
            z3 <= z3_next;
        end
    end

    assign r = z1 ^ z2 ^ z3;
endmodule

module epf_channel_multistate #(
    parameter int          SYMBOL_W   = 2,
    parameter int          NUM_STATES = 4,
    parameter int          CNT_W      = 48,
    parameter logic [63:0] RNG_SEED0  = 64'h1391A0B350391A0B,
    parameter logic [63:0] RNG_SEED1  = 64'h50391A0B0392A7D3,
    parameter logic [63:0] RNG_SEED2  = 64'h0392A7D350391A0B
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic [SYMBOL_W-1:0]           symbol_in,
    input  logic [63:0]                   probability_in,
    input  logic [31:0]                   probability_idx,
    input  logic                          sign_mode,
    input  logic                          sat_mode,
    output logic [SYMBOL_W-1:0]           symbol_out,
    output logic                          valid,
    output logic                          err_flag,
    output logic [CNT_W-1:0]              symbol_count,
    output logic [CNT_W-1:0]              error_count,
    output logic [CNT_W-1:0]              burst_count,
    output logic [$clog2(NUM_STATES)-1:0] state_out
);
    localparam int                   ST_W    = $clog2(NUM_STATES);
    localparam logic [ST_W-1:0]      MAX_ST  = ST_W'(NUM_STATES - 1);
    localparam logic [SYMBOL_W-1:0]  MAX_SYM = {SYMBOL_W{1'b1}};
    localparam logic [SYMBOL_W-1:0]  ONE_SYM = SYMBOL_W'(1);

    logic [63:0]         r;
    logic [ST_W-1:0]     state, next_state;
    logic                sign, neg, hit;
    logic                sign_mode_q, sat_mode_q;
    logic [SYMBOL_W-1:0] err_sym;

    // NOTE: the table has no reset branch on purpose; it must survive rstn so it can be
    // loaded during the reset window and kept across later resets.
    logic [63:0] prob [NUM_STATES] = '{default: '0};

    urng_64 #(.SEED0(RNG_SEED0), .SEED1(RNG_SEED1), .SEED2(RNG_SEED2)) u_rng (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .r    (r)
    );

    always_ff @(posedge clk) begin
        if (!rstn && probability_idx < 32'(NUM_STATES))
            prob[probability_idx[ST_W-1:0]] <= probability_in;
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        hit        = r < prob[state];
        neg        = sign_mode_q ? r[0] : sign;
        err_sym    = symbol_in;
        next_state = '0;
        if (sat_mode_q) begin
            if (!neg) err_sym = (symbol_in == MAX_SYM) ? MAX_SYM - ONE_SYM : symbol_in + ONE_SYM;
            else      err_sym = (symbol_in == '0)      ? ONE_SYM           : symbol_in - ONE_SYM;
        end else begin
            err_sym = neg ? symbol_in - ONE_SYM : symbol_in + ONE_SYM;
        end
        if (hit)
            next_state = (state == MAX_ST) ? MAX_ST : state + ST_W'(1);
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid        <= 1'b0;
            err_flag     <= 1'b0;
            symbol_out   <= '0;
            state        <= '0;
            sign         <= 1'b0;
            symbol_count <= '0;
            error_count  <= '0;
            burst_count  <= '0;
            sign_mode_q  <= sign_mode;
            sat_mode_q   <= sat_mode;
        end else begin
            valid <= en;
            if (en) begin
                state        <= next_state;
                symbol_count <= sat_inc(symbol_count);
                if (state == '0) begin
                    symbol_out <= symbol_in;
                    err_flag   <= 1'b0;
                    if (hit) begin
                        burst_count <= sat_inc(burst_count);
                        sign        <= 1'b0;
                    end
                end else begin
                    symbol_out  <= err_sym;
                    err_flag    <= 1'b1;
                    error_count <= sat_inc(error_count);
                    sign        <= ~sign;
                end
            end
        end
    end

    assign state_out = state;
endmodule

// File: tb/tb_epf_channel_multistate.sv
// Directed bench for epf_channel_multistate using 0 / all-ones probabilities so every
// expected output is deterministic and hand-derived; counters shrunk to 10 bits to reach saturation.
module tb_epf_channel_multistate;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] NOLD = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rstn, en, sign_mode, sat_mode;
    logic [1:0]  symbol_in;
    logic [63:0] probability_in;
    logic [31:0] probability_idx;
    logic [1:0]  symbol_out;
    logic        valid, err_flag;
    logic [9:0]  symbol_count, error_count, burst_count;
    logic [1:0]  state_out;

    int n_cmp = 0;
    int n_bad = 0;

    epf_channel_multistate #(.SYMBOL_W(2), .NUM_STATES(4), .CNT_W(10)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .en              (en),
        .symbol_in       (symbol_in),
        .probability_in  (probability_in),
        .probability_idx (probability_idx),
        .sign_mode       (sign_mode),
        .sat_mode        (sat_mode),
        .symbol_out      (symbol_out),
        .valid           (valid),
        .err_flag        (err_flag),
        .symbol_count    (symbol_count),
        .error_count     (error_count),
        .burst_count     (burst_count),
        .state_out       (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_begin(input logic sm, input logic tm);
        rstn = 1'b0; en = 1'b0; probability_idx = NOLD;
        sign_mode = sm; sat_mode = tm;
        tick();
    endtask

    task automatic load(input logic [31:0] idx, input logic [63:0] p);
        probability_idx = idx; probability_in = p;
        tick();
        probability_idx = NOLD;
    endtask

    task automatic reset_end(input string tag);
        check({tag, "_rst_valid"}, valid, 0);
        check({tag, "_rst_err"}, err_flag, 0);
        check({tag, "_rst_sym"}, symbol_out, 0);
        check({tag, "_rst_state"}, state_out, 0);
        check({tag, "_rst_cnt"}, {symbol_count, error_count, burst_count}, 0);
        rstn = 1'b1;
    endtask

    task automatic step(input string tag, input logic [1:0] sym, input logic [1:0] eo,
                        input logic ee, input logic [1:0] es);
        en = 1'b1; symbol_in = sym;
        tick();
        check({tag, "_out"}, symbol_out, eo);
        check({tag, "_err"}, err_flag, ee);
        check({tag, "_state"}, state_out, es);
        check({tag, "_valid"}, valid, 1);
    endtask

    initial begin
        logic [1:0] s;
        rstn = 1'b0; en = 1'b0; symbol_in = '0; probability_in = '0;
        probability_idx = NOLD; sign_mode = 1'b0; sat_mode = 1'b0;

        // Power-up table is all zero: straight pass-through with one cycle latency.
        reset_begin(0, 0);
        tick();
        reset_end("t1");
        for (int i = 0; i < 1000; i++) begin
            s = 2'($urandom_range(3));
            en = 1'b1; symbol_in = s;
            tick();
            check("t1_sym", symbol_out, s);
            check("t1_err", err_flag, 0);
        end
        check("t1_symcnt", symbol_count, 1000);
        check("t1_errcnt", error_count, 0);
        check("t1_burst", burst_count, 0);
        for (int i = 0; i < 30; i++) tick();
        check("t1_symcnt_sat", symbol_count, 10'h3FF);

        // Wrap + alternating, all-ones table, symbol 3: 3,0,2,0,2,0 and state saturates.
        reset_begin(0, 0);
        for (int i = 0; i < 4; i++) load(i, ONES);
        reset_end("t2");
        for (int k = 0; k < 6; k++)
            step("t2", 2'd3, (k == 0) ? 2'd3 : ((k % 2) ? 2'd0 : 2'd2), k != 0,
                 (k < 2) ? 2'(k + 1) : 2'd3);
        check("t2_burst", burst_count, 1);
        check("t2_errcnt", error_count, 5);
        check("t2_symcnt", symbol_count, 6);

        // en toggling mid-burst: everything holds while en=0, valid follows en.
        for (int k = 0; k < 4; k++) begin
            en = k[0]; symbol_in = 2'd3;
            tick();
            check("t4_valid", valid, k[0]);
            check("t4_state", state_out, 3);
            check("t4_out", symbol_out, (k == 0) ? 2'd0 : ((k == 1) ? 2'd2 : ((k == 2) ? 2'd2 : 2'd0)));
            check("t4_symcnt", symbol_count, 6 + (k + 1) / 2);
            check("t4_errcnt", error_count, 5 + (k + 1) / 2);
            check("t4_burst", burst_count, 1);
        end

        // Reset mid-burst, loads to idx 7 and FFFFFFFF must not touch P[3].
        reset_begin(0, 1);
        load(0, ONES);
        load(1, ONES);
        load(7, 64'h0);
        load(NOLD, 64'h0);
        reset_end("t5");
        for (int k = 0; k < 6; k++)
            step("t5", 2'd3, (k == 0) ? 2'd3 : 2'd2, k != 0, (k < 2) ? 2'(k + 1) : 2'd3);

        // Reset without load keeps the table; reflect at 0 gives 1 for both directions.
        reset_begin(0, 1);
        tick();
        reset_end("t6");
        for (int k = 0; k < 5; k++)
            step("t6", 2'd0, (k == 0) ? 2'd0 : 2'd1, k != 0, (k < 2) ? 2'(k + 1) : 2'd3);

        // P[1]=0: clean/error alternation, one burst per two symbols.
        reset_begin(0, 1);
        load(1, 64'h0);
        reset_end("t3");
        for (int k = 0; k < 8; k++)
            step("t3", 2'd0, 2'(k % 2), k % 2 == 1, 2'((k + 1) % 2));
        check("t3_burst", burst_count, 4);
        check("t3_errcnt", error_count, 4);
        check("t3_symcnt", symbol_count, 8);

        // Random sign, wrap mode, symbol 1: every error output is 0 or 2.
        reset_begin(1, 0);
        load(1, ONES);
        reset_end("t7");
        for (int k = 0; k < 20; k++) begin
            en = 1'b1; symbol_in = 2'd1;
            tick();
            if (k == 0) check("t7_clean", symbol_out, 1);
            else        check("t7_pm1", (symbol_out == 2'd0) || (symbol_out == 2'd2), 1);
        end
        check("t7_errcnt", error_count, 19);
        check("t7_burst", burst_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
